// File: rtl/ex_mdu_seq.sv
// ex_mdu_seq: iterative EX-stage multiply/divide unit.
// One shift-add (MUL/MULHU) or restoring shift-subtract (DIVU/REMU)
// step per cycle; holds the pipeline via stall until done.
// Optional divider datapath: define MDU_DIV_EN.
// Ports: clk, reset (async, active-high), start, op[1:0], dataA,
//   dataB, flush -> stall (comb), done (1-cycle pulse), result (held).

`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module ex_mdu_seq #(
  parameter int REG_WIDTH = `REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [REG_WIDTH-1:0] dataA,
  input  logic [REG_WIDTH-1:0] dataB,
  input  logic                 flush,
  output logic                 stall,
  output logic                 done,
  output logic [REG_WIDTH-1:0] result
);

  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(REG_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(REG_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;

  logic          accept;
  logic          skip;
  logic          last;
  logic [W-1:0]  skip_res;
  logic [W-1:0]  step_acc;
  logic [W-1:0]  step_lo;
  logic [W-1:0]  fin_res;
  logic [W:0]    mul_sum;

  // New ops are only taken outside BUSY; flush always wins.
  assign accept = (state_q != BUSY) && start && !flush;
  assign last   = (state_q == BUSY) && (cnt_q == LAST);

  // {acc,lo} is the running product (acc high, lo low/multiplier)
  // or {remainder,dividend->quotient} for divides.
  assign mul_sum = {1'b0, acc_q} + {1'b0, {W{lo_q[0]}} & b_q};

`ifdef MDU_DIV_EN
  logic [W:0]   div_rs;
  logic         div_ge;
  logic [W-1:0] div_diff;

  // Divide by zero resolves at accept without iterating.
  assign skip     = op[1] && (dataB == '0);
  assign skip_res = op[0] ? dataA : '1;

  // Remainder stays below the divisor, so W bits suffice after the
  // subtract; the truncated difference is exact whenever div_ge.
  assign div_rs   = {acc_q, lo_q[W-1]};
  assign div_ge   = div_rs >= {1'b0, b_q};
  assign div_diff = div_rs[W-1:0] - b_q;
`else
  // No divider: divide ops complete immediately with zero.
  assign skip     = op[1];
  assign skip_res = '0;
`endif

  always_comb begin
    step_acc = mul_sum[W:1];
    step_lo  = {mul_sum[0], lo_q[W-1:1]};
`ifdef MDU_DIV_EN
    if (op_q[1]) begin
      step_acc = div_ge ? div_diff : div_rs[W-1:0];
      step_lo  = {lo_q[W-2:0], div_ge};
    end
`endif
  end

  always_comb begin
    fin_res = '0;
    unique case (op_q)
      2'b00: fin_res = step_lo;
      2'b01: fin_res = step_acc;
`ifdef MDU_DIV_EN
      2'b10: fin_res = step_lo;
      2'b11: fin_res = step_acc;
`else
      2'b10: fin_res = '0;
      2'b11: fin_res = '0;
`endif
      default: fin_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) state_d = skip ? DONE : BUSY;
          else        state_d = IDLE;
        end
        BUSY: begin
          if (last) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs; stall is held low while reset is asserted.
  always_comb begin
    stall  = !reset && ((state_q == BUSY) || accept);
    done   = (state_q == DONE);
    result = res_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    acc_d = acc_q;
    lo_d  = lo_q;
    b_d   = b_q;
    res_d = res_q;
    if (accept) begin
      op_d  = op;
      cnt_d = '0;
      acc_d = '0;
      lo_d  = dataA;
      b_d   = dataB;
      if (skip) res_d = skip_res;
    end else if ((state_q == BUSY) && !flush) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = step_acc;
      lo_d  = step_lo;
      if (last) res_d = fin_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      acc_q <= acc_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_mdu_seq.sv
// tb_ex_mdu_seq: self-checking bench for ex_mdu_seq (REG_WIDTH=32).
// Vector table, random ops vs. arithmetic model, hand corner cases.

module tb_ex_mdu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [1:0]   op;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         stall;
  logic         done;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mdu_seq #(.REG_WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .dataA  (dataA),
    .dataB  (dataB),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [1:0] o,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'b00: return p[W-1:0];
      2'b01: return p[2*W-1:W];
`ifdef MDU_DIV_EN
      2'b10: return (b == '0) ? '1 : a / b;
      default: return (b == '0) ? a : a % b;
`else
      default: return '0;
`endif
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o,
                                 input logic [W-1:0] b);
    if (!o[1]) return W + 1;
`ifdef MDU_DIV_EN
    return (b == '0) ? 1 : W + 1;
`else
    if (b == '0) return 1;
    return 1;
`endif
  endfunction

  // Starts an op in the current cycle (called just after a rising
  // edge), waits for done and checks latency, result and stall.
  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat,
                        input bit noise);
    int n;
    bit seen;
    int bad;
    op = o;
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(negedge clk);
    chk({nm, " stall@start"}, W'(stall), W'(1));
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    seen = 1'b0;
    bad = 0;
    while (!seen && n < 200) begin
      n++;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!stall) bad++;
        if (noise && n < lat) begin
          start = 1'($urandom);
          op    = 2'($urandom);
          dataA = $urandom;
          dataB = $urandom;
        end
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    chk({nm, " done"}, W'(seen), W'(1));
    chk({nm, " latency"}, W'(n), W'(lat));
    chk({nm, " result"}, result, exp);
    chk({nm, " stall@done"}, W'(stall), W'(0));
    chk({nm, " stall busy"}, W'(bad), W'(0));
    if (seen) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic no_done(input string nm, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) hits++;
    end
    chk({nm, " no done"}, W'(hits), W'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit seen;
    logic [1:0] o;
    logic [W-1:0] a;
    logic [W-1:0] b;

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    dataA = '0;
    dataB = '0;

    vt.push_back('{"mul 7*6", 2'b00, 7, 6, 42, W + 1});
    vt.push_back('{"mulhu max", 2'b01, '1, '1, 32'hFFFF_FFFE, W + 1});
    vt.push_back('{"mul wrap", 2'b00, '1, '1, 32'h1, W + 1});
`ifdef MDU_DIV_EN
    vt.push_back('{"divu 100/7", 2'b10, 100, 7, 14, W + 1});
    vt.push_back('{"remu 100/7", 2'b11, 100, 7, 2, W + 1});
    vt.push_back('{"divu 5/0", 2'b10, 5, 0, '1, 1});
    vt.push_back('{"remu 5/0", 2'b11, 5, 0, 5, 1});
    vt.push_back('{"divu max/1", 2'b10, '1, 1, '1, W + 1});
`else
    vt.push_back('{"divu 100/7", 2'b10, 100, 7, 0, 1});
    vt.push_back('{"remu 100/7", 2'b11, 100, 7, 0, 1});
    vt.push_back('{"divu 5/0", 2'b10, 5, 0, 0, 1});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stall", W'(stall), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset result", result, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      run_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b,
             vt[i].exp, vt[i].lat, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = $urandom_range(1, 300);
      run_op("random", o, a, b, ref_res(o, a, b), ref_lat(o, b), 1'b1);
    end

    // MULHU followed by MUL 3*5 accepted in the DONE cycle.
    op = 2'b01;
    dataA = '1;
    dataB = '1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      n++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("b2b first result", result, 32'hFFFF_FFFE);
    op = 2'b00;
    dataA = 3;
    dataB = 5;
    start = 1'b1;
    #1;
    chk("b2b stall@done+start", W'(stall), W'(1));
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      n++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("b2b second latency", W'(n), W'(W + 1));
    chk("b2b second result", result, 15);
    @(posedge clk);
    #1;

    // Flush in cycle 10 of a MUL.
    op = 2'b00;
    dataA = 32'h1234;
    dataB = 32'h5678;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush stall", W'(stall), W'(0));
    chk("flush done", W'(done), W'(0));
    chk("flush result kept", result, 15);
    no_done("flush", 40);

    // Flush and start together: nothing accepted.
    op = 2'b00;
    dataA = 9;
    dataB = 9;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush+start stall", W'(stall), W'(0));
    @(posedge clk);
    #1 begin
      start = 1'b0;
      flush = 1'b0;
    end
    no_done("flush+start", 40);
    chk("flush+start result", result, 15);

    // Reset at cycle 15 of a DIVU.
    op = 2'b10;
    dataA = 100;
    dataB = 7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("midop reset stall", W'(stall), W'(0));
    chk("midop reset done", W'(done), W'(0));
    chk("midop reset result", result, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    no_done("midop reset", 40);

    run_op("post reset mul", 2'b00, 32'hFFFF, 32'h10001,
           32'hFFFF_FFFF, W + 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mdu_seq.md
EX_MDU_SEQ -- requirements
Module: ex_mdu_seq

Interface
REQ-001 SHALL have parameter REG_WIDTH, default `REG_WIDTH (32), operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  EX stage requests a multiply/divide op this cycle.
REQ-005 SHALL have port op  input  2  00 MUL (low half), 01 MULHU (unsigned high half), 10 DIVU, 11 REMU.
REQ-006 SHALL have port dataA  input  REG_WIDTH  forwarded operand A (multiplicand/dividend).
REQ-007 SHALL have port dataB  input  REG_WIDTH  forwarded operand B (multiplier/divisor).
REQ-008 SHALL have port flush  input  1  pipeline flush; abort any op in progress.
REQ-009 SHALL have port stall  output  1  hold IF/ID/EX pipeline registers while the op is running.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port result  output  REG_WIDTH  op result, held until the next done.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; the iteration counter SHALL be $clog2(REG_WIDTH)+1 bits wide.
REQ-013 In IDLE or DONE with start=1 and flush=0, SHALL latch op, dataA, dataB, clear counter and go to BUSY; start is ignored in BUSY.
REQ-014 BUSY SHALL perform one iteration per cycle: shift-add for MUL/MULHU (2*REG_WIDTH-bit product), restoring shift-subtract for DIVU/REMU.
REQ-015 After exactly REG_WIDTH BUSY cycles, SHALL go to DONE; DONE lasts one cycle, then IDLE unless start is accepted per REQ-013.
REQ-016 Latency: start sampled at edge N -> done=1 in cycle N+REG_WIDTH+1, and result updates at that same edge.
REQ-017 result SHALL be product[REG_WIDTH-1:0] for MUL, product[2*REG_WIDTH-1:REG_WIDTH] for MULHU, quotient for DIVU, remainder for REMU, all unsigned.
REQ-018 stall SHALL be combinational: 1 when (IDLE or DONE) and start=1 and flush=0, or when state=BUSY; 0 otherwise (0 in DONE without start).
REQ-019 done SHALL be 1 only in DONE.
REQ-020 Divide by zero (DIVU/REMU with dataB=0 at accept) SHALL skip BUSY and go to DONE the next cycle: DIVU result all ones, REMU result = dataA.
REQ-021 flush=1 SHALL force IDLE at the next edge from any state and suppress done; result keeps its prior value.
REQ-022 flush and start in the same cycle: flush SHALL win, and no op is accepted.

Reset
REQ-023 reset=1 SHALL asynchronously force state IDLE, counter 0, result 0, done 0, stall 0, and clear all operand/partial registers.
REQ-024 reset asserted mid-op SHALL discard the op; no done pulse follows deassertion.

Configuration
REQ-025 Macro MDU_DIV_EN SHALL compile in the divider datapath and the REQ-020 handling.
REQ-026 Without MDU_DIV_EN, ops 10/11 SHALL skip BUSY, go to DONE the next cycle with result 0, and no divider logic SHALL be present; MUL/MULHU are unchanged.

Verification (REG_WIDTH=32)
REQ-027 MUL 7*6, start at cycle 0 -> stall=1 cycles 0..32, done=1 in cycle 33, result=42, stall=0 in cycle 33.
REQ-028 MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE; back-to-back MUL 3*5 with start in the DONE cycle -> second done 33 cycles later, result 15.
REQ-029 MDU_DIV_EN set: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> done the next cycle, result 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-030 MUL started, flush at cycle 10 -> IDLE at cycle 11, stall=0, no done, result unchanged; flush+start in the same cycle -> no op accepted.
REQ-031 reset pulsed at cycle 15 of DIVU -> all outputs 0 immediately, no done afterwards; MDU_DIV_EN unset: DIVU 100/7 -> done the next cycle, result 0.
